// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit: single-cycle-issue multiply with
// configurable latency, radix-2 restoring divide, and HI/LO moves.
module hilo_muldiv #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + MUL_LAT + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvs;
  logic               neg_q;
  logic               neg_r;
  logic               dz;

  logic               sgn;
  logic [2*WIDTH-1:0] ps;
  logic [2*WIDTH-1:0] pu;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     t;
  logic [WIDTH:0]     diff;
  logic               qbit;
  logic [WIDTH-1:0]   rem_n;
  logic [WIDTH-1:0]   quo_n;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  // MULT and DIV (even opcodes) are the signed flavours
  assign sgn = ~op[0];

  assign ps = $signed({{WIDTH{src_a[WIDTH-1]}}, src_a})
            * $signed({{WIDTH{src_b[WIDTH-1]}}, src_b});
  assign pu = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

  // Divide on magnitudes; signs are restored at commit
  always_comb begin
    a_mag = src_a;
    b_mag = src_b;
    if (sgn && src_a[WIDTH-1]) a_mag = '0 - src_a;
    if (sgn && src_b[WIDTH-1]) b_mag = '0 - src_b;
  end

  // One restoring-division step plus sign fix-up of its result
  always_comb begin
    t     = {rem, quo[WIDTH-1]};
    diff  = t - {1'b0, dvs};
    qbit  = ~diff[WIDTH];
    rem_n = qbit ? diff[WIDTH-1:0] : t[WIDTH-1:0];
    quo_n = {quo[WIDTH-2:0], qbit};
    q_fix = neg_q ? '0 - quo_n : quo_n;
    r_fix = neg_r ? '0 - rem_n : rem_n;
  end

  // Control FSM, working registers and HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              unique case (op)
                3'b000, 3'b001: begin
                  prod  <= sgn ? ps : pu;
                  cnt   <= CW'(MUL_LAT - 1);
                  state <= MUL;
                  busy  <= 1'b1;
                end
                3'b010, 3'b011: begin
                  rem   <= '0;
                  quo   <= a_mag;
                  dvs   <= b_mag;
                  neg_q <= sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                  neg_r <= sgn & src_a[WIDTH-1];
                  dz    <= (src_b == '0);
                  cnt   <= '0;
                  state <= DIV;
                  busy  <= 1'b1;
                end
                3'b100:  hi <= src_a;
                3'b101:  lo <= src_a;
                default: ;
              endcase
            end
          end
          MUL: begin
            if (cnt == '0) begin
              hi    <= prod[2*WIDTH-1:WIDTH];
              lo    <= prod[WIDTH-1:0];
              done  <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          DIV: begin
            if (dz) begin
              done     <= 1'b1;
              div_zero <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else if (cnt == CW'(WIDTH - 1)) begin
              lo    <= q_fix;
              hi    <= r_fix;
              done  <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              rem <= rem_n;
              quo <= quo_n;
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed-vector bench for hilo_muldiv (WIDTH=32, MUL_LAT=1).
// Each task drives one scenario and checks against hand values.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b111;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad = 0;

  hilo_muldiv #(.WIDTH(32), .MUL_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Present a request for the next edge, then scramble the inputs
  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b111; src_a = 32'hDEAD_BEEF; src_b = '0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({busy, done, div_zero} !== 3'b000) begin
      bad++; $display("FAIL reset_ctl got=%b want=000", {busy, done, div_zero});
    end
    total++;
    if ({hi, lo} !== 64'h0) begin
      bad++; $display("FAIL reset_hilo got=%h want=0", {hi, lo});
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_mt();
    issue(3'b100, 32'h1234_5678, 32'h0);
    total++;
    if (hi !== 32'h1234_5678 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL mthi hi=%h busy=%b done=%b want=12345678/0/0", hi, busy, done);
    end
    issue(3'b101, 32'h9ABC_DEF0, 32'h0);
    total++;
    if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678 || busy !== 1'b0) begin
      bad++; $display("FAIL mtlo hi=%h lo=%h busy=%b want=12345678/9abcdef0/0", hi, lo, busy);
    end
  endtask

  task automatic test_mult();
    issue(3'b000, 32'hFFFF_FFFF, 32'h2);
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL mult_busy busy=%b done=%b want=1/0", busy, done);
    end
    @(posedge clk); #1;
    total++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFE || done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL mult got=%h done=%b want=fffffffffffffffe/1", {hi, lo}, done);
    end
  endtask

  task automatic test_back_to_back();
    issue(3'b001, 32'hFFFF_FFFF, 32'h2);
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_accept busy=%b done=%b want=1/0", busy, done);
    end
    @(posedge clk); #1;
    total++;
    if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE || done !== 1'b1) begin
      bad++; $display("FAIL multu got=%h done=%b want=00000001fffffffe/1", {hi, lo}, done);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL multu_pulse done=%b busy=%b want=0/0", done, busy);
    end
  endtask

  task automatic test_divu();
    int n = 0;
    int early = 0;
    issue(3'b011, 32'd100, 32'd7);
    while (busy === 1'b1 && n < 40) begin
      if (done !== 1'b0) early++;
      n++;
      @(posedge clk); #1;
    end
    total++;
    if (n != 32 || early != 0) begin
      bad++; $display("FAIL divu_busy cycles=%0d early_done=%0d want=32/0", n, early);
    end
    total++;
    if (lo !== 32'hE || hi !== 32'h2 || done !== 1'b1 || div_zero !== 1'b0) begin
      bad++; $display("FAIL divu got lo=%h hi=%h done=%b dz=%b want=e/2/1/0", lo, hi, done, div_zero);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL divu_pulse done=%b want=0", done);
    end
  endtask

  task automatic test_div();
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    repeat (32) @(posedge clk);
    #1;
    total++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || done !== 1'b1) begin
      bad++; $display("FAIL div_neg lo=%h hi=%h done=%b want=fffffffd/ffffffff/1", lo, hi, done);
    end
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (32) @(posedge clk);
    #1;
    total++;
    if (lo !== 32'h8000_0000 || hi !== 32'h0 || done !== 1'b1) begin
      bad++; $display("FAIL div_ovf lo=%h hi=%h done=%b want=80000000/0/1", lo, hi, done);
    end
  endtask

  task automatic test_div_zero();
    issue(3'b011, 32'd5, 32'd0);
    @(posedge clk); #1;
    total++;
    if (done !== 1'b1 || div_zero !== 1'b1 || lo !== 32'h8000_0000 || hi !== 32'h0) begin
      bad++; $display("FAIL divz done=%b dz=%b lo=%h hi=%h want=1/1/80000000/0", done, div_zero, lo, hi);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || div_zero !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL divz_pulse done=%b dz=%b busy=%b want=0/0/0", done, div_zero, busy);
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    issue(3'b100, 32'hAAAA_AAAA, 32'h0);
    issue(3'b101, 32'h5555_5555, 32'h0);
    issue(3'b011, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    issue(3'b101, 32'h1111_1111, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'hAAAA_AAAA || lo !== 32'h5555_5555) begin
      bad++; $display("FAIL flush busy=%b done=%b hi=%h lo=%h want=0/0/aaaaaaaa/55555555", busy, done, hi, lo);
    end
    repeat (30) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    total++;
    if (seen != 0 || lo !== 32'h5555_5555) begin
      bad++; $display("FAIL flush_quiet events=%0d lo=%h want=0/55555555", seen, lo);
    end
  endtask

  task automatic test_flush_priority();
    flush = 1'b1;
    issue(3'b100, 32'h7777_7777, 32'h0);
    flush = 1'b0;
    total++;
    if (hi !== 32'hAAAA_AAAA || busy !== 1'b0) begin
      bad++; $display("FAIL flush_mthi hi=%h busy=%b want=aaaaaaaa/0", hi, busy);
    end
    issue(3'b001, 32'd3, 32'd4);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'hAAAA_AAAA || lo !== 32'h5555_5555) begin
      bad++; $display("FAIL flush_commit done=%b busy=%b hi=%h lo=%h want=0/0/aaaaaaaa/55555555", done, busy, hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    issue(3'b010, 32'd1000, 32'd3);
    repeat (19) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      bad++; $display("FAIL reset_mid busy=%b hi=%h lo=%h want=0/0/0", busy, hi, lo);
    end
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    issue(3'b011, 32'd9, 32'd3);
    repeat (32) @(posedge clk);
    #1;
    total++;
    if (lo !== 32'd3 || hi !== 32'd0 || done !== 1'b1) begin
      bad++; $display("FAIL divu_after_reset lo=%h hi=%h done=%b want=3/0/1", lo, hi, done);
    end
  endtask

  initial begin
    test_reset();
    test_mt();
    test_mult();
    test_back_to_back();
    test_divu();
    test_div();
    test_div_zero();
    test_flush();
    test_flush_priority();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width; legal values are even and at least 8.
REQ-002 Parameter MUL_LAT, default 1, multiply latency in cycles; legal values are at least 1.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  operation request; sampled only in IDLE.
REQ-006 op  input  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are no-ops.
REQ-007 src_a  input  WIDTH  multiplicand, dividend, or move data.
REQ-008 src_b  input  WIDTH  multiplier or divisor.
REQ-009 flush  input  1  abort request (pipeline exception cancel).
REQ-010 busy  output  1  a multi-cycle operation is in flight.
REQ-011 done  output  1  one-cycle pulse: a MULT, MULTU, DIV or DIVU has committed.
REQ-012 div_zero  output  1  valid with done: the divide had a zero divisor.
REQ-013 hi  output  WIDTH  HI register.
REQ-014 lo  output  WIDTH  LO register.

Function
REQ-015 The FSM SHALL have three states: IDLE, MUL and DIV.
- IDLE -> MUL on start with op MULT or MULTU.
- IDLE -> DIV on start with op DIV or DIVU.
REQ-016 busy SHALL be 1 exactly when the state is MUL or DIV.
REQ-017 Start sampled at edge N with MTHI or MTLO SHALL write src_a into hi or lo at edge N; busy and done stay 0.
REQ-018 Start sampled at edge N with MULT or MULTU:
- the full 2*WIDTH-bit product is written at edge N+MUL_LAT, upper half to hi, lower half to lo;
- done is high during the following cycle;
- the FSM returns to IDLE at the same edge.
REQ-019 MULT SHALL treat both operands as two's complement; MULTU SHALL treat them as unsigned.
REQ-020 DIV/DIVU with nonzero src_b SHALL iterate one quotient bit per cycle.
- Quotient to lo and remainder to hi at edge N+WIDTH.
- done is high during the following cycle.
REQ-021 DIV rounding:
- quotient truncated toward zero;
- remainder nonzero takes the sign of the dividend;
- most-negative / -1 yields lo = most-negative, hi = 0.
REQ-022 DIV/DIVU with src_b = 0 SHALL leave hi/lo unchanged, assert done and div_zero during cycle N+1, and return to IDLE at edge N+1.
REQ-023 Operands and op SHALL be latched at edge N; later changes to src_a, src_b or op SHALL NOT affect an in-flight operation.
REQ-024 start while busy SHALL be ignored, with no queueing.
REQ-025 flush asserted at a rising edge SHALL:
- return the FSM to IDLE;
- leave hi/lo unchanged;
- suppress done.
REQ-026 flush SHALL take priority over start in the same cycle, including MTHI/MTLO.
REQ-027 flush at the edge where a result would commit SHALL suppress that commit.
REQ-028 A new start SHALL be accepted in the cycle in which done is high.
REQ-029 done and div_zero SHALL be 0 in every cycle not named above.

Reset
REQ-030 While reset is 1, the block SHALL:
- hold hi = 0 and lo = 0;
- hold busy, done and div_zero at 0;
- hold the FSM in IDLE;
- clear the iteration counter and working registers.
REQ-031 reset asserted mid-operation SHALL abort the operation immediately; no partial result reaches hi or lo.
REQ-032 The first start SHALL be sampled at the first rising edge after reset deasserts.

Verification (WIDTH=32, MUL_LAT=1)
REQ-033 MULT with src_a=0xFFFFFFFF, src_b=2 -> one cycle later hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulse; MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-034 DIVU with 100/7 -> busy for 32 cycles, then lo=0x0000000E, hi=0x00000002, single done pulse; DIV with -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 DIV with 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU with 5/0 -> done and div_zero next cycle, hi/lo unchanged.
REQ-036 MTHI 0x12345678, then MTLO 0x9ABCDEF0 -> hi/lo take these values on successive edges; busy stays 0.
REQ-037 DIVU started, second start with MTLO at cycle 5, flush at cycle 10 -> MTLO ignored, no done, hi/lo keep prior values, IDLE next cycle.
REQ-038 DIV started, reset pulsed asynchronously at cycle 20 -> hi=lo=0 and busy=0 immediately; a subsequent DIVU 9/3 yields lo=3, hi=0.
